// File: rtl/vector_logic_controller.sv
// Purpose: sequences a SIZE_IN-element bitwise logic op (AND..PASS) over requested A/B operand pairs.
// Latency: result 1 cycle after the pair completes; READY or next request 2 cycles after; >= 3 cycles/element.
// Backpressure: operands are pulled with a one-cycle DATA_ENABLE request; the engine waits indefinitely in INPUT.
// Optional build macro VECTOR_LOGIC_ERROR_EN adds the ERROR output (zero-size start, duplicate operand enable).
module vector_logic_controller #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [2:0]              OPCODE_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic                    DATA_A_IN_ENABLE,
    input  logic                    DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_A_IN,
    input  logic [DATA_SIZE-1:0]    DATA_B_IN,
    output logic                    DATA_ENABLE,
    output logic                    DATA_OUT_ENABLE,
    output logic [CONTROL_SIZE-1:0] INDEX_OUT,
    output logic [DATA_SIZE-1:0]    DATA_OUT
`ifdef VECTOR_LOGIC_ERROR_EN
    ,
    output logic                    ERROR
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INPUT = 2'd1,
        ENDER = 2'd2,
        NEXT  = 2'd3
    } state_t;

    state_t                    state;
    state_t                    state_nxt;

    logic [CONTROL_SIZE-1:0]   size_r;
    logic [CONTROL_SIZE-1:0]   index_r;
    logic [2:0]                opcode_r;
    logic [DATA_SIZE-1:0]      a_r;
    logic [DATA_SIZE-1:0]      b_r;
    logic                      a_vld;
    logic                      b_vld;

    logic                      ready_nxt;
    logic                      data_enable_nxt;
    logic                      data_out_enable_nxt;

    logic                      in_input;
    logic                      a_take;
    logic                      b_take;
    logic                      pair_done;
    logic                      last_elem;
    logic [DATA_SIZE-1:0]      a_eff;
    logic [DATA_SIZE-1:0]      b_eff;
    logic [DATA_SIZE-1:0]      result;

    // Bitwise operation selected by the latched opcode; NOT and PASS look at A only.
    function automatic logic [DATA_SIZE-1:0] apply_op(input logic [2:0]           op,
                                                      input logic [DATA_SIZE-1:0] a,
                                                      input logic [DATA_SIZE-1:0] b);
        logic [DATA_SIZE-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a ^ b);
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // An operand already held keeps precedence: a repeat enable for it never overwrites it.
    always_comb begin
        in_input  = (state == INPUT);
        a_take    = in_input && DATA_A_IN_ENABLE && !a_vld;
        b_take    = in_input && DATA_B_IN_ENABLE && !b_vld;
        pair_done = (a_vld || DATA_A_IN_ENABLE) && (b_vld || DATA_B_IN_ENABLE);
        a_eff     = a_vld ? a_r : DATA_A_IN;
        b_eff     = b_vld ? b_r : DATA_B_IN;
        result    = apply_op(opcode_r, a_eff, b_eff);
        // size_r is never zero once a vector is running, so size_r-1 cannot underflow here.
        last_elem = (index_r == (size_r - CONTROL_SIZE'(1)));
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and next values of the one-cycle pulse outputs.
    always_comb begin
        state_nxt           = state;
        ready_nxt           = 1'b0;
        data_enable_nxt     = 1'b0;
        data_out_enable_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    if (SIZE_IN == '0) begin
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt       = INPUT;
                        data_enable_nxt = 1'b1;
                    end
                end
            end
            INPUT: begin
                if (pair_done) begin
                    state_nxt           = ENDER;
                    data_out_enable_nxt = 1'b1;
                end
            end
            ENDER: begin
                state_nxt       = NEXT;
                ready_nxt       = last_elem;
                data_enable_nxt = !last_elem;
            end
            NEXT: begin
                state_nxt = last_elem ? IDLE : INPUT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pulse outputs are registered so they are glitch-free single-cycle strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            READY           <= 1'b0;
            DATA_ENABLE     <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
        end else begin
            READY           <= ready_nxt;
            DATA_ENABLE     <= data_enable_nxt;
            DATA_OUT_ENABLE <= data_out_enable_nxt;
        end
    end

    // Run context, operand capture, element index and held result.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            size_r    <= '0;
            opcode_r  <= '0;
            index_r   <= '0;
            a_r       <= '0;
            b_r       <= '0;
            a_vld     <= 1'b0;
            b_vld     <= 1'b0;
            DATA_OUT  <= '0;
            INDEX_OUT <= '0;
        end else begin
            if ((state == IDLE) && START) begin
                size_r   <= SIZE_IN;
                opcode_r <= OPCODE_IN;
                index_r  <= '0;
            end
            if (a_take) begin
                a_r   <= DATA_A_IN;
                a_vld <= 1'b1;
            end
            if (b_take) begin
                b_r   <= DATA_B_IN;
                b_vld <= 1'b1;
            end
            if (in_input && pair_done) begin
                DATA_OUT  <= result;
                INDEX_OUT <= index_r;
            end
            if (state == ENDER) begin
                a_vld <= 1'b0;
                b_vld <= 1'b0;
            end
            if ((state == NEXT) && !last_elem) begin
                index_r <= index_r + CONTROL_SIZE'(1);
            end
        end
    end

`ifdef VECTOR_LOGIC_ERROR_EN
    logic error_nxt;

    // Flag a zero-length start or a repeat enable for an operand that is already held.
    always_comb begin
        error_nxt = ((state == IDLE) && START && (SIZE_IN == '0)) ||
                    (in_input && ((DATA_A_IN_ENABLE && a_vld) || (DATA_B_IN_ENABLE && b_vld)));
    end

    // ERROR is a one-cycle registered pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERROR <= 1'b0;
        end else begin
            ERROR <= error_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_vector_logic_controller.sv
// Purpose: self-checking bench for vector_logic_controller (DATA_SIZE=8, CONTROL_SIZE=8).
// Latency: checks result at c+1 and READY at c+2 after the completing operand.
// Backpressure: operands are driven the cycle after each DATA_ENABLE request, with variable A/B gaps.
module tb_vector_logic_controller;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          START = 1'b0;
    logic          READY;
    logic [2:0]    OPCODE_IN = '0;
    logic [CW-1:0] SIZE_IN = '0;
    logic          DATA_A_IN_ENABLE = 1'b0;
    logic          DATA_B_IN_ENABLE = 1'b0;
    logic [DW-1:0] DATA_A_IN = '0;
    logic [DW-1:0] DATA_B_IN = '0;
    logic          DATA_ENABLE;
    logic          DATA_OUT_ENABLE;
    logic [CW-1:0] INDEX_OUT;
    logic [DW-1:0] DATA_OUT;
`ifdef VECTOR_LOGIC_ERROR_EN
    logic          ERROR;
`endif

    vector_logic_controller #(
        .DATA_SIZE    (DW),
        .CONTROL_SIZE (CW)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .START            (START),
        .READY            (READY),
        .OPCODE_IN        (OPCODE_IN),
        .SIZE_IN          (SIZE_IN),
        .DATA_A_IN_ENABLE (DATA_A_IN_ENABLE),
        .DATA_B_IN_ENABLE (DATA_B_IN_ENABLE),
        .DATA_A_IN        (DATA_A_IN),
        .DATA_B_IN        (DATA_B_IN),
        .DATA_ENABLE      (DATA_ENABLE),
        .DATA_OUT_ENABLE  (DATA_OUT_ENABLE),
        .INDEX_OUT        (INDEX_OUT),
        .DATA_OUT         (DATA_OUT)
`ifdef VECTOR_LOGIC_ERROR_EN
        ,
        .ERROR            (ERROR)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [CW-1:0] idx;
        logic [DW-1:0] dat;
    } res_t;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
    } vec_t;

    res_t sb_q[$];
    res_t obs_q[$];
    int   tests = 0;
    int   fails = 0;
    int   de_cnt = 0;
    int   doe_cnt = 0;
    int   rdy_cnt = 0;

    // Observe pulses and results away from the active edge.
    always @(negedge CLK) begin
        if (DATA_ENABLE) de_cnt++;
        if (READY) rdy_cnt++;
        if (DATA_OUT_ENABLE) begin
            doe_cnt++;
            obs_q.push_back('{idx: INDEX_OUT, dat: DATA_OUT});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare every produced result with the expected result queued at stimulus time.
    task automatic drain(input string tag);
        res_t o;
        res_t e;
        chk({tag, "_result_count"}, 64'(obs_q.size()), 64'(sb_q.size()));
        while (obs_q.size() > 0 && sb_q.size() > 0) begin
            o = obs_q.pop_front();
            e = sb_q.pop_front();
            chk({tag, "_data"}, 64'(o.dat), 64'(e.dat));
            chk({tag, "_index"}, 64'(o.idx), 64'(e.idx));
        end
        obs_q.delete();
        sb_q.delete();
    endtask

    // START for one cycle, then scramble size/opcode to prove they were latched.
    task automatic start_run(input logic [CW-1:0] size, input logic [2:0] op);
        START     = 1'b1;
        SIZE_IN   = size;
        OPCODE_IN = op;
        tick();
        START     = 1'b0;
        SIZE_IN   = ~size;
        OPCODE_IN = op ^ 3'd5;
    endtask

    task automatic wait_de(input string tag);
        int n = 0;
        while (!DATA_ENABLE && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_request"}, 64'(DATA_ENABLE), 64'd1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!READY && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(READY), 64'd1);
        tick();
    endtask

    // One element: wait for the request, A first, B 'gap' cycles later; repeat A enables in between.
    task automatic do_elem(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int gap, input logic [CW-1:0] idx, input logic [DW-1:0] exp);
        wait_de(tag);
        tick();
        DATA_A_IN_ENABLE = 1'b1;
        DATA_A_IN        = a;
        if (gap == 0) begin
            DATA_B_IN_ENABLE = 1'b1;
            DATA_B_IN        = b;
            sb_q.push_back('{idx: idx, dat: exp});
            tick();
        end else begin
            tick();
            for (int k = 1; k < gap; k++) begin
                DATA_A_IN = ~a;
                tick();
            end
            DATA_A_IN_ENABLE = 1'b0;
            DATA_B_IN_ENABLE = 1'b1;
            DATA_B_IN        = b;
            sb_q.push_back('{idx: idx, dat: exp});
            tick();
        end
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
    endtask

    vec_t          tbl[9];
    logic [DW-1:0] ta[3];
    logic [DW-1:0] tb2[3];
    logic [DW-1:0] e2[3][3];
    int            d0, o0, r0;

    initial begin
        tbl[0] = '{op: 3'd6, a: 8'h55, b: 8'h12, exp: 8'hAA};
        tbl[1] = '{op: 3'd4, a: 8'hFF, b: 8'h0F, exp: 8'hF0};
        tbl[2] = '{op: 3'd5, a: 8'h00, b: 8'h00, exp: 8'hFF};
        tbl[3] = '{op: 3'd3, a: 8'hF0, b: 8'hAA, exp: 8'hA5};
        tbl[4] = '{op: 3'd0, a: 8'h3C, b: 8'h0F, exp: 8'h0C};
        tbl[5] = '{op: 3'd1, a: 8'h3C, b: 8'h0F, exp: 8'h3F};
        tbl[6] = '{op: 3'd2, a: 8'h3C, b: 8'h0F, exp: 8'h33};
        tbl[7] = '{op: 3'd7, a: 8'h5A, b: 8'hFF, exp: 8'h5A};
        tbl[8] = '{op: 3'd3, a: 8'h00, b: 8'h00, exp: 8'hFF};
        ta  = '{8'h3C, 8'hA5, 8'h00};
        tb2 = '{8'h0F, 8'hFF, 8'hFF};
        e2  = '{'{8'h0C, 8'hA5, 8'h00}, '{8'h3F, 8'hFF, 8'hFF}, '{8'h33, 8'h5A, 8'hFF}};

        // Reset state.
        tick();
        tick();
        chk("reset_ready", 64'(READY), 64'd0);
        chk("reset_data_enable", 64'(DATA_ENABLE), 64'd0);
        chk("reset_out_enable", 64'(DATA_OUT_ENABLE), 64'd0);
        chk("reset_data_out", 64'(DATA_OUT), 64'd0);
        chk("reset_index_out", 64'(INDEX_OUT), 64'd0);
        RST = 1'b1;
        tick();

        // Single XNOR element, exact cycle timing.
        start_run(8'd1, 3'd3);
        chk("t1_request", 64'(DATA_ENABLE), 64'd1);
        tick();
        DATA_A_IN_ENABLE = 1'b1;
        DATA_A_IN        = 8'hF0;
        DATA_B_IN_ENABLE = 1'b1;
        DATA_B_IN        = 8'hAA;
        sb_q.push_back('{idx: 8'd0, dat: 8'hA5});
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
        chk("t1_out_enable", 64'(DATA_OUT_ENABLE), 64'd1);
        chk("t1_data_out", 64'(DATA_OUT), 64'hA5);
        chk("t1_ready_early", 64'(READY), 64'd0);
        tick();
        chk("t1_ready", 64'(READY), 64'd1);
        tick();
        chk("t1_hold_data", 64'(DATA_OUT), 64'hA5);
        chk("t1_ready_pulse", 64'(READY), 64'd0);
        drain("t1");

        // Three elements, AND/OR/XOR in turn, B two cycles after A.
        for (int op = 0; op < 3; op++) begin
            d0 = de_cnt; o0 = doe_cnt; r0 = rdy_cnt;
            start_run(8'd3, 3'(op));
            for (int k = 0; k < 3; k++) do_elem("t2", ta[k], tb2[k], 2, 8'(k), e2[op][k]);
            wait_ready("t2");
            tick();
            chk("t2_request_count", 64'(de_cnt - d0), 64'd3);
            chk("t2_result_count_pulses", 64'(doe_cnt - o0), 64'd3);
            chk("t2_ready_count", 64'(rdy_cnt - r0), 64'd1);
            drain("t2");
        end

        // Zero-length vector.
        d0 = de_cnt; o0 = doe_cnt; r0 = rdy_cnt;
        start_run(8'd0, 3'd0);
        chk("t3_ready", 64'(READY), 64'd1);
`ifdef VECTOR_LOGIC_ERROR_EN
        chk("t3_error", 64'(ERROR), 64'd1);
`endif
        tick();
        chk("t3_ready_pulse", 64'(READY), 64'd0);
        for (int k = 0; k < 5; k++) tick();
        chk("t3_no_request", 64'(de_cnt - d0), 64'd0);
        chk("t3_no_result", 64'(doe_cnt - o0), 64'd0);
        chk("t3_ready_count", 64'(rdy_cnt - r0), 64'd1);
        drain("t3");

        // START mid-vector with a different size/opcode is ignored.
        d0 = de_cnt; o0 = doe_cnt; r0 = rdy_cnt;
        start_run(8'd2, 3'd0);
        wait_de("t4");
        tick();
        START     = 1'b1;
        SIZE_IN   = 8'd5;
        OPCODE_IN = 3'd1;
        tick();
        START = 1'b0;
        DATA_A_IN_ENABLE = 1'b1;
        DATA_A_IN        = 8'h3C;
        DATA_B_IN_ENABLE = 1'b1;
        DATA_B_IN        = 8'h0F;
        sb_q.push_back('{idx: 8'd0, dat: 8'h0C});
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b0;
        do_elem("t4", 8'hA5, 8'h0F, 0, 8'd1, 8'h05);
        wait_ready("t4");
        for (int k = 0; k < 8; k++) tick();
        chk("t4_request_count", 64'(de_cnt - d0), 64'd2);
        chk("t4_result_pulses", 64'(doe_cnt - o0), 64'd2);
        chk("t4_ready_count", 64'(rdy_cnt - r0), 64'd1);
        drain("t4");

        // Reset while waiting for B on element 1 of 4.
        start_run(8'd4, 3'd2);
        do_elem("t5", 8'h11, 8'h22, 0, 8'd0, 8'h33);
        wait_de("t5");
        tick();
        DATA_A_IN_ENABLE = 1'b1;
        DATA_A_IN        = 8'h77;
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        tick();
        #2;
        RST = 1'b0;
        #1;
        chk("t5_rst_ready", 64'(READY), 64'd0);
        chk("t5_rst_data_enable", 64'(DATA_ENABLE), 64'd0);
        chk("t5_rst_out_enable", 64'(DATA_OUT_ENABLE), 64'd0);
        chk("t5_rst_data_out", 64'(DATA_OUT), 64'd0);
        chk("t5_rst_index_out", 64'(INDEX_OUT), 64'd0);
        tick();
        tick();
        RST = 1'b1;
        drain("t5a");
        d0 = de_cnt; o0 = doe_cnt; r0 = rdy_cnt;
        for (int k = 0; k < 10; k++) tick();
        chk("t5_idle_requests", 64'(de_cnt - d0), 64'd0);
        chk("t5_idle_results", 64'(doe_cnt - o0), 64'd0);
        chk("t5_idle_ready", 64'(rdy_cnt - r0), 64'd0);
        start_run(8'd1, 3'd7);
        wait_de("t5b");
        tick();
        DATA_B_IN_ENABLE = 1'b1;
        DATA_B_IN        = 8'h99;
        tick();
        DATA_B_IN_ENABLE = 1'b0;
        DATA_A_IN_ENABLE = 1'b1;
        DATA_A_IN        = 8'h42;
        sb_q.push_back('{idx: 8'd0, dat: 8'h42});
        tick();
        DATA_A_IN_ENABLE = 1'b0;
        wait_ready("t5b");
        drain("t5b");

        // Opcode table, one single-element vector per entry.
        for (int i = 0; i < 9; i++) begin
            start_run(8'd1, tbl[i].op);
            do_elem("tbl", tbl[i].a, tbl[i].b, i % 3, 8'd0, tbl[i].exp);
            wait_ready("tbl");
            drain($sformatf("tbl%0d", i));
        end

`ifdef VECTOR_LOGIC_ERROR_EN
        // Repeat enable for a held operand gives a one-cycle ERROR; data still discarded.
        start_run(8'd1, 3'd0);
        wait_de("err");
        tick();
        DATA_A_IN_ENABLE = 1'b1;
        DATA_A_IN        = 8'hF0;
        tick();
        DATA_A_IN        = 8'h00;
        tick();
        chk("err_dup_pulse", 64'(ERROR), 64'd1);
        DATA_A_IN_ENABLE = 1'b0;
        DATA_B_IN_ENABLE = 1'b1;
        DATA_B_IN        = 8'hFF;
        sb_q.push_back('{idx: 8'd0, dat: 8'hF0});
        tick();
        DATA_B_IN_ENABLE = 1'b0;
        chk("err_dup_clear", 64'(ERROR), 64'd0);
        wait_ready("err");
        drain("err");
`endif

        // Largest size for this width: 255 elements, index must not wrap early.
        d0 = de_cnt; o0 = doe_cnt; r0 = rdy_cnt;
        start_run(8'd255, 3'd1);
        for (int k = 0; k < 255; k++) do_elem("big", 8'(k), 8'h00, 0, 8'(k), 8'(k));
        wait_ready("big");
        for (int k = 0; k < 4; k++) tick();
        chk("big_request_count", 64'(de_cnt - d0), 64'd255);
        chk("big_result_pulses", 64'(doe_cnt - o0), 64'd255);
        chk("big_ready_count", 64'(rdy_cnt - r0), 64'd1);
        drain("big");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
